// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GAP,
      SHOW,
      HIT,
      DONE
   } state_t;

   localparam int unsigned NUM_OVALS = 5;
   localparam logic [2:0]  OVAL_NONE = 3'd0;

   // Fibonacci feedback taps 8,6,5,4 (bit 7 is tap 8)
   localparam logic [7:0]  LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/mole_scheduler_if.sv
// Game-side signal bundle between the stimulus (buttons, frame pacing) and the sequencer.
interface mole_scheduler_if;
   import mole_pkg::*;

   logic                 start;
   logic                 frame_tick;
   logic [NUM_OVALS-1:0] hit_btn;
   logic [2:0]           oval_select;
   logic                 mole_visible;
   logic                 hit_flash;
   logic [7:0]           score;
   logic [7:0]           misses;
   logic [7:0]           round;
   logic                 game_over;

   modport master (
      output start, frame_tick, hit_btn,
      input  oval_select, mole_visible, hit_flash, score, misses, round, game_over
   );

   modport slave (
      input  start, frame_tick, hit_btn,
      output oval_select, mole_visible, hit_flash, score, misses, round, game_over
   );

endinterface

// File: rtl/mole_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick mole positions.
module mole_lfsr8
   import mole_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seed,
   output logic [7:0] state
);

   logic [7:0] state_q;
   logic [7:0] state_d;

   // Shift left, feeding back the XOR of the tapped bits
   always_comb begin
      state_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
   end

   // State register, advances every cycle
   always_ff @(posedge clk) begin
      if (reset) state_q <= seed;
      else       state_q <= state_d;
   end

   assign state = state_q;

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: chooses the oval, times show/gap/hit phases, keeps score.
module mole_scheduler
   import mole_pkg::*;
#(
   parameter int unsigned SHOW_FRAMES = 60,
   parameter int unsigned GAP_FRAMES  = 30,
   parameter int unsigned HIT_FRAMES  = 15,
   parameter int unsigned MAX_ROUNDS  = 20,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
)(
   input  logic             clk,
   input  logic             reset,
   mole_scheduler_if.slave  bus
);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] score_q, score_d;
   logic [7:0] misses_q, misses_d;
   logic [7:0] round_q, round_d;
   logic [2:0] prev_oval_q, prev_oval_d;
   logic [2:0] oval_q, oval_d;
   logic       visible_q, visible_d;
   logic       flash_q, flash_d;
   logic       game_over_q, game_over_d;

   logic [7:0]           lfsr;
   logic                 unused_lfsr_hi;
   logic [NUM_OVALS-1:0] oval_mask;
   logic                 round_end;
   logic [7:0]           round_inc;

   mole_lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .state (lfsr)
   );

   // Only the low three LFSR bits select the oval
   assign unused_lfsr_hi = ^lfsr[7:3];

   // Map l in 0..7 onto 1..5, bumping past the previous oval to avoid repeats
   function automatic logic [2:0] pick_oval(input logic [2:0] l, input logic [2:0] prev);
      logic [2:0] cand;
      cand = (l < 3'(NUM_OVALS)) ? l + 3'd1 : l - 3'd4;
      if (cand == prev) cand = (cand == 3'(NUM_OVALS)) ? 3'd1 : cand + 3'd1;
      return cand;
   endfunction

   // Next-state, counters and registered-output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      score_d     = score_q;
      misses_d    = misses_q;
      round_d     = round_q;
      prev_oval_d = prev_oval_q;
      oval_d      = oval_q;
      round_end   = 1'b0;
      round_inc   = round_q + 8'd1;
      oval_mask   = NUM_OVALS'(1) << (oval_q - 3'd1);

      if (bus.frame_tick) cnt_d = cnt_q + 8'd1;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               score_d     = '0;
               misses_d    = '0;
               round_d     = '0;
               prev_oval_d = OVAL_NONE;
               oval_d      = OVAL_NONE;
               state_d     = GAP;
            end
         end
         GAP: begin
            if (bus.frame_tick && cnt_q == 8'(GAP_FRAMES - 1)) begin
               oval_d      = pick_oval(lfsr[2:0], prev_oval_q);
               prev_oval_d = oval_d;
               state_d     = SHOW;
            end
         end
         SHOW: begin
            // A hit takes priority over a timeout in the same cycle
            if (|(bus.hit_btn & oval_mask)) begin
               score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
               state_d = HIT;
            end else if (bus.frame_tick && cnt_q == 8'(SHOW_FRAMES - 1)) begin
               misses_d  = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
               round_end = 1'b1;
            end
         end
         HIT: begin
            if (bus.frame_tick && cnt_q == 8'(HIT_FRAMES - 1)) round_end = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (round_end) begin
         round_d = round_inc;
         oval_d  = OVAL_NONE;
         state_d = (round_inc == 8'(MAX_ROUNDS)) ? DONE : GAP;
      end

      // Any state change restarts the frame count, including a tick that triggered it
      if (state_d != state_q) cnt_d = '0;

      visible_d   = (state_d == SHOW);
      flash_d     = (state_d == HIT);
      game_over_d = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         score_q     <= '0;
         misses_q    <= '0;
         round_q     <= '0;
         prev_oval_q <= OVAL_NONE;
         oval_q      <= OVAL_NONE;
         visible_q   <= 1'b0;
         flash_q     <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         score_q     <= score_d;
         misses_q    <= misses_d;
         round_q     <= round_d;
         prev_oval_q <= prev_oval_d;
         oval_q      <= oval_d;
         visible_q   <= visible_d;
         flash_q     <= flash_d;
         game_over_q <= game_over_d;
      end
   end

   assign bus.oval_select  = oval_q;
   assign bus.mole_visible = visible_q;
   assign bus.hit_flash    = flash_q;
   assign bus.score        = score_q;
   assign bus.misses       = misses_q;
   assign bus.round        = round_q;
   assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler with SHOW=4, GAP=2, HIT=1, ROUNDS=3.
module tb_mole_scheduler;
   import mole_pkg::*;

   localparam logic [7:0] SEED = 8'hA5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mole_scheduler_if bus();

   mole_scheduler #(
      .SHOW_FRAMES (4),
      .GAP_FRAMES  (2),
      .HIT_FRAMES  (1),
      .MAX_ROUNDS  (3),
      .LFSR_SEED   (SEED)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic [2:0] oval;
      logic       vis;
      logic       flash;
      logic       go;
      logic [7:0] score;
      logic [7:0] misses;
      logic [7:0] round;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   logic [2:0] e_oval = 3'd0, e_prev = 3'd0;
   logic       e_vis = 1'b0, e_flash = 1'b0, e_go = 1'b0;
   logic [7:0] e_score = 8'd0, e_misses = 8'd0, e_round = 8'd0;

   // Reference LFSR: taps 8,6,5,4, reset to the seed, steps every clock
   logic [7:0] m_lfsr;
   always @(posedge clk) begin
      if (reset) m_lfsr <= SEED;
      else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [2:0] ref_pick(input logic [2:0] l, input logic [2:0] prev);
      logic [2:0] c;
      if (l < 3'd5) c = l + 3'd1;
      else          c = l - 3'd4;
      if (c == prev) c = (c == 3'd5) ? 3'd1 : c + 3'd1;
      return c;
   endfunction

   function automatic logic [4:0] hmask(input logic [2:0] o);
      logic [4:0] one;
      one = 5'd1;
      return one << (o - 3'd1);
   endfunction

   task automatic chk(input string name, input string field, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
      end
   endtask

   // Apply one cycle of inputs, then queue the expected post-edge outputs
   task automatic drive(input logic st, input logic tk, input logic [4:0] hb,
                        input bit do_pick, input string tag);
      logic [7:0] snap;
      exp_t x;
      snap = m_lfsr;
      bus.start = st;
      bus.frame_tick = tk;
      bus.hit_btn = hb;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.frame_tick = 1'b0;
      bus.hit_btn = 5'd0;
      if (do_pick) begin
         e_oval = ref_pick(snap[2:0], e_prev);
         e_prev = e_oval;
      end
      x.tag = tag;
      x.oval = e_oval;
      x.vis = e_vis;
      x.flash = e_flash;
      x.go = e_go;
      x.score = e_score;
      x.misses = e_misses;
      x.round = e_round;
      sbq.push_back(x);
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation
   always @(negedge clk) begin : mon
      exp_t x;
      if (sbq.size() > 0) begin
         x = sbq.pop_front();
         chk(x.tag, "oval_select", int'(bus.oval_select), int'(x.oval));
         chk(x.tag, "mole_visible", int'(bus.mole_visible), int'(x.vis));
         chk(x.tag, "hit_flash", int'(bus.hit_flash), int'(x.flash));
         chk(x.tag, "game_over", int'(bus.game_over), int'(x.go));
         chk(x.tag, "score", int'(bus.score), int'(x.score));
         chk(x.tag, "misses", int'(bus.misses), int'(x.misses));
         chk(x.tag, "round", int'(bus.round), int'(x.round));
         if (bus.mole_visible === 1'b1)
            chk(x.tag, "oval_in_range",
                int'(bus.oval_select >= 3'd1 && bus.oval_select <= 3'd5), 1);
      end
   end

   initial begin
      bus.start = 1'b0;
      bus.frame_tick = 1'b0;
      bus.hit_btn = 5'd0;

      // Reset dominates a start pulse
      reset = 1'b1;
      drive(1, 1, 5'h1f, 0, "reset");
      drive(0, 0, 5'h00, 0, "reset_hold");
      reset = 1'b0;

      // Idle: ticks and buttons do nothing
      repeat (3) drive(0, 1, 5'h00, 0, "idle_tick");
      drive(0, 0, 5'h1f, 0, "idle_hit");

      // Start with a simultaneous tick: the tick must not count towards GAP
      drive(1, 1, 5'h00, 0, "start_gap");
      drive(0, 1, 5'h00, 0, "r1_gap_tick");
      e_vis = 1'b1;
      drive(0, 1, 5'h00, 1, "r1_show");

      // Round 1: wrong buttons and a stray start, then time out
      drive(0, 0, ~hmask(e_oval) & 5'h1f, 0, "r1_wrong_btn");
      drive(1, 0, 5'h00, 0, "r1_start_ignored");
      repeat (3) drive(0, 1, 5'h00, 0, "r1_show_tick");
      e_vis = 1'b0; e_oval = 3'd0; e_misses = 8'd1; e_round = 8'd1;
      drive(0, 1, 5'h00, 0, "r1_timeout");

      // Round 2: matching hit, flash held until one frame passes
      drive(0, 1, 5'h00, 0, "r2_gap_tick");
      drive(1, 0, 5'h00, 0, "r2_gap_start_ignored");
      e_vis = 1'b1;
      drive(0, 1, 5'h00, 1, "r2_show");
      drive(0, 1, 5'h00, 0, "r2_show_tick");
      e_vis = 1'b0; e_flash = 1'b1; e_score = 8'd1;
      drive(0, 0, hmask(e_oval), 0, "r2_hit");
      drive(0, 0, 5'h1f, 0, "r2_hit_btn_ignored");
      drive(1, 0, 5'h00, 0, "r2_hit_start_ignored");
      e_flash = 1'b0; e_oval = 3'd0; e_round = 8'd2;
      drive(0, 1, 5'h00, 0, "r2_hit_end");

      // Round 3: hit on the same cycle as the final show tick wins
      drive(0, 1, 5'h00, 0, "r3_gap_tick");
      e_vis = 1'b1;
      drive(0, 1, 5'h00, 1, "r3_show");
      repeat (3) drive(0, 1, 5'h00, 0, "r3_show_tick");
      e_vis = 1'b0; e_flash = 1'b1; e_score = 8'd2;
      drive(0, 1, hmask(e_oval), 0, "r3_hit_and_timeout");
      e_flash = 1'b0; e_oval = 3'd0; e_round = 8'd3; e_go = 1'b1;
      drive(0, 1, 5'h00, 0, "r3_done");

      // Done: counters frozen
      repeat (2) drive(0, 1, 5'h1f, 0, "done_frozen");

      // Restart from DONE clears counters and the previous oval
      e_go = 1'b0; e_score = 8'd0; e_misses = 8'd0; e_round = 8'd0; e_prev = 3'd0;
      drive(1, 0, 5'h00, 0, "restart");
      drive(0, 1, 5'h00, 0, "g2_gap_tick");
      e_vis = 1'b1;
      drive(0, 1, 5'h00, 1, "g2_show");
      drive(0, 1, 5'h00, 0, "g2_show_tick");

      // Reset mid-SHOW aborts to IDLE and restarts the LFSR
      reset = 1'b1;
      e_vis = 1'b0; e_oval = 3'd0; e_prev = 3'd0;
      drive(0, 1, 5'h00, 0, "reset_in_show");
      reset = 1'b0;
      drive(0, 1, 5'h00, 0, "idle_after_reset");
      drive(1, 0, 5'h00, 0, "g3_start");
      drive(0, 1, 5'h00, 0, "g3_gap_tick");
      e_vis = 1'b1;
      drive(0, 1, 5'h00, 1, "g3_show");

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      if (sbq.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
